// File: rtl/exe_wb_stage_if.sv
// Execute-to-writeback bundle: execute-side inputs, register-file write port,
// forwarding/bypass outputs and the retired counter of exe_wb_stage.
interface exe_wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_result;
  logic [DATA_W-1:0]     in_cpsr_val;
  logic [REG_ADDR_W-1:0] in_dst;
  logic                  in_reg_we;
  logic                  in_flag_we;
  logic                  hold;
  logic                  flush;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_dst;
  logic [DATA_W-1:0]     fwd_data;
  logic [DATA_W-1:0]     cpsr_q;
  logic [DATA_W-1:0]     cpsr_fwd;
  logic [CNT_W-1:0]      retired;

  modport master (
    output in_valid, in_result, in_cpsr_val, in_dst, in_reg_we, in_flag_we,
           hold, flush,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_dst, fwd_data,
           cpsr_q, cpsr_fwd, retired
  );

  modport slave (
    input  in_valid, in_result, in_cpsr_val, in_dst, in_reg_we, in_flag_we,
           hold, flush,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_dst, fwd_data,
           cpsr_q, cpsr_fwd, retired
  );
endinterface

// File: rtl/exe_wb_stage.sv
// Writeback pipeline register: commits ALU result and NZCV flags, exposes
// register/CPSR forwarding and counts retired instructions.
module exe_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  exe_wb_stage_if.slave  bus
);
  logic                  r_v;
  logic [DATA_W-1:0]     r_result;
  logic [REG_ADDR_W-1:0] r_dst;
  logic                  r_reg_we;
  logic                  r_flag_we;
  logic [3:0]            r_flags;
  logic [3:0]            r_cpsr_nzcv;
  logic [CNT_W-1:0]      r_retired;

  logic                  w_commit;
  logic [DATA_W-1:0]     w_cpsr_q;
  logic                  w_unused_cpsr_low;

  // Only NZCV is architecturally meaningful; the low flag-word bits are dropped.
  assign w_unused_cpsr_low = ^bus.in_cpsr_val[DATA_W-5:0];

  assign w_commit = r_v & ~bus.hold;
  assign w_cpsr_q = {r_cpsr_nzcv, {(DATA_W-4){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v         <= 1'b0;
      r_result    <= '0;
      r_dst       <= '0;
      r_reg_we    <= 1'b0;
      r_flag_we   <= 1'b0;
      r_flags     <= '0;
      r_cpsr_nzcv <= '0;
      r_retired   <= '0;
    end else begin
      // A stall freezes the stage entirely, so flush is only honoured when free.
      if (!bus.hold) begin
        if (bus.flush) begin
          r_v <= 1'b0;
        end else if (bus.in_valid) begin
          r_v       <= 1'b1;
          r_result  <= bus.in_result;
          r_dst     <= bus.in_dst;
          r_reg_we  <= bus.in_reg_we;
          r_flag_we <= bus.in_flag_we;
          r_flags   <= bus.in_cpsr_val[DATA_W-1:DATA_W-4];
        end else begin
          r_v <= 1'b0;
        end
      end
      if (w_commit) begin
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        if (r_flag_we) begin
          r_cpsr_nzcv <= r_flags;
        end
      end
    end
  end

  assign bus.in_ready  = ~bus.hold;
  assign bus.rf_we     = w_commit & r_reg_we;
  assign bus.rf_waddr  = r_dst;
  assign bus.rf_wdata  = r_result;
  assign bus.fwd_valid = r_v & r_reg_we;
  assign bus.fwd_dst   = r_dst;
  assign bus.fwd_data  = r_result;
  assign bus.cpsr_q    = w_cpsr_q;
  // Bypass shows the pending flag update even while the stage is stalled.
  assign bus.cpsr_fwd  = (r_v & r_flag_we) ? {r_flags, {(DATA_W-4){1'b0}}} : w_cpsr_q;
  assign bus.retired   = r_retired;
endmodule

// File: tb/tb_exe_wb_stage.sv
// Bench for exe_wb_stage: directed scenarios plus randomized traffic checked
// against a queue-based model of in-flight and committed instructions.
module tb_exe_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exe_wb_stage_if #(.DATA_W(32), .REG_ADDR_W(3), .CNT_W(32)) bif();
  exe_wb_stage_if #(.DATA_W(32), .REG_ADDR_W(3), .CNT_W(4))  bif4();

  exe_wb_stage #(.DATA_W(32), .REG_ADDR_W(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave)
  );
  exe_wb_stage #(.DATA_W(32), .REG_ADDR_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bif4.slave)
  );

  assign bif4.in_valid    = bif.in_valid;
  assign bif4.in_result   = bif.in_result;
  assign bif4.in_cpsr_val = bif.in_cpsr_val;
  assign bif4.in_dst      = bif.in_dst;
  assign bif4.in_reg_we   = bif.in_reg_we;
  assign bif4.in_flag_we  = bif.in_flag_we;
  assign bif4.hold        = bif.hold;
  assign bif4.flush       = bif.flush;

  typedef struct {
    logic [31:0] result;
    logic [2:0]  dst;
    logic        reg_we;
    logic        flag_we;
    logic [3:0]  flags;
  } ins_t;

  ins_t        pend[$];
  logic [3:0]  m_nzcv;
  logic [31:0] m_retired;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic model_reset();
    pend.delete();
    m_nzcv = 4'h0;
    m_retired = 32'd0;
  endtask

  // One clock edge; the model retires the held instruction and accepts the offer.
  task automatic tick();
    ins_t n;
    if (!rst_n) begin
      model_reset();
    end else if (!bif.hold) begin
      if (pend.size() > 0) begin
        n = pend.pop_front();
        m_retired = m_retired + 32'd1;
        if (n.flag_we) m_nzcv = n.flags;
      end
      if (!bif.flush && bif.in_valid) begin
        n.result  = bif.in_result;
        n.dst     = bif.in_dst;
        n.reg_we  = bif.in_reg_we;
        n.flag_we = bif.in_flag_we;
        n.flags   = bif.in_cpsr_val[31:28];
        pend.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] res, input logic [31:0] cpsr,
                       input logic [2:0] dst, input logic rwe, input logic fwe);
    bif.in_valid = v; bif.in_result = res; bif.in_cpsr_val = cpsr;
    bif.in_dst = dst; bif.in_reg_we = rwe; bif.in_flag_we = fwe;
  endtask

  task automatic test_reset();
    offer(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    bif.hold = 1'b0; bif.flush = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if ({bif.rf_we, bif.fwd_valid, bif.cpsr_q, bif.cpsr_fwd, bif.retired, bif4.retired} !== '0) begin
      n_fail++; $display("FAIL reset_init got rf_we=%b fwd_valid=%b cpsr_q=%h cpsr_fwd=%h retired=%0d exp all 0",
                         bif.rf_we, bif.fwd_valid, bif.cpsr_q, bif.cpsr_fwd, bif.retired);
    end
    rst_n = 1'b1;
    offer(1'b1, 32'hDEAD_BEEF, 32'hF000_0000, 3'd6, 1'b1, 1'b1);
    tick();
    offer(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bif.fwd_valid !== 1'b1 || bif.cpsr_fwd !== 32'hF000_0000) begin
      n_fail++; $display("FAIL reset_preload got fwd_valid=%b cpsr_fwd=%h exp 1 f0000000", bif.fwd_valid, bif.cpsr_fwd);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bif.rf_we, bif.fwd_valid, bif.cpsr_fwd, bif.cpsr_q, bif.retired} !== '0) begin
      n_fail++; $display("FAIL reset_async got rf_we=%b fwd_valid=%b cpsr_fwd=%h cpsr_q=%h retired=%0d exp all 0",
                         bif.rf_we, bif.fwd_valid, bif.cpsr_fwd, bif.cpsr_q, bif.retired);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bif.rf_we !== 1'b0 || bif.retired !== 32'd0 || bif.cpsr_q !== 32'd0) begin
      n_fail++; $display("FAIL reset_after got rf_we=%b retired=%0d cpsr_q=%h exp 0 0 0", bif.rf_we, bif.retired, bif.cpsr_q);
    end
  endtask

  task automatic test_single_write();
    offer(1'b1, 32'h0000_002A, 32'hF000_0000, 3'd3, 1'b1, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bif.rf_we !== 1'b1 || bif.rf_waddr !== 3'd3 || bif.rf_wdata !== 32'h2A) begin
      n_fail++; $display("FAIL single_write got we=%b addr=%0d data=%h exp 1 3 0000002a", bif.rf_we, bif.rf_waddr, bif.rf_wdata);
    end
    tick();
    n_checks++;
    if (bif.retired !== 32'd1 || bif.cpsr_q !== 32'd0 || bif.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL single_after got retired=%0d cpsr_q=%h rf_we=%b exp 1 0 0", bif.retired, bif.cpsr_q, bif.rf_we);
    end
  endtask

  task automatic test_flags();
    offer(1'b1, 32'h1234_5678, 32'h6000_0000, 3'd2, 1'b0, 1'b1);
    tick();
    offer(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bif.cpsr_fwd !== 32'h6000_0000 || bif.cpsr_q !== 32'h0 || bif.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL flags_bypass got cpsr_fwd=%h cpsr_q=%h rf_we=%b exp 60000000 0 0", bif.cpsr_fwd, bif.cpsr_q, bif.rf_we);
    end
    tick();
    n_checks++;
    if (bif.cpsr_q !== 32'h6000_0000 || bif.cpsr_fwd !== 32'h6000_0000) begin
      n_fail++; $display("FAIL flags_commit got cpsr_q=%h cpsr_fwd=%h exp 60000000", bif.cpsr_q, bif.cpsr_fwd);
    end
  endtask

  task automatic test_hold();
    int pulses;
    logic [31:0] exp_ret;
    pulses = 0;
    offer(1'b1, 32'hCAFE_0005, 32'h9000_0000, 3'd5, 1'b1, 1'b1);
    tick();
    exp_ret = m_retired + 32'd1;
    offer(1'b1, 32'h0BAD_0BAD, 32'h0, 3'd7, 1'b1, 1'b0);
    bif.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bif.rf_we !== 1'b0 || bif.in_ready !== 1'b0 || bif.fwd_valid !== 1'b1 || bif.cpsr_fwd !== 32'h9000_0000) begin
        n_fail++; $display("FAIL hold_cycle%0d got rf_we=%b in_ready=%b fwd_valid=%b cpsr_fwd=%h exp 0 0 1 90000000",
                           c, bif.rf_we, bif.in_ready, bif.fwd_valid, bif.cpsr_fwd);
      end
      tick();
    end
    bif.hold = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bif.rf_we === 1'b1) begin
        pulses++;
        n_checks++;
        if (bif.rf_waddr !== 3'd5 || bif.rf_wdata !== 32'hCAFE_0005) begin
          n_fail++; $display("FAIL hold_release_data got addr=%0d data=%h exp 5 cafe0005", bif.rf_waddr, bif.rf_wdata);
        end
      end
      tick();
    end
    n_checks++;
    if (pulses != 1 || bif.retired !== exp_ret || bif.cpsr_q !== 32'h9000_0000) begin
      n_fail++; $display("FAIL hold_release got pulses=%0d retired=%0d cpsr_q=%h exp 1 %0d 90000000",
                         pulses, bif.retired, bif.cpsr_q, exp_ret);
    end
  endtask

  task automatic test_flush();
    offer(1'b1, 32'h0000_0011, 32'h0, 3'd1, 1'b1, 1'b0);
    tick();
    offer(1'b1, 32'h0000_0022, 32'hF000_0000, 3'd2, 1'b1, 1'b1);
    bif.flush = 1'b1;
    #1;
    n_checks++;
    if (bif.rf_we !== 1'b1 || bif.rf_waddr !== 3'd1 || bif.rf_wdata !== 32'h11) begin
      n_fail++; $display("FAIL flush_commit got we=%b addr=%0d data=%h exp 1 1 00000011", bif.rf_we, bif.rf_waddr, bif.rf_wdata);
    end
    tick();
    bif.flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (bif.rf_we !== 1'b0 || bif.fwd_valid !== 1'b0 || bif.cpsr_q !== 32'h9000_0000) begin
        n_fail++; $display("FAIL flush_discard%0d got rf_we=%b fwd_valid=%b cpsr_q=%h exp 0 0 90000000",
                           c, bif.rf_we, bif.fwd_valid, bif.cpsr_q);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        e_we, e_fv;
    logic [31:0] e_cq, e_cf;
    int          errs;
    for (int c = 0; c < 400; c++) begin
      offer(($urandom_range(0, 9) < 7), $urandom, $urandom, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bif.hold  = ($urandom_range(0, 3) == 0);
      bif.flush = ($urandom_range(0, 6) == 0);
      #1;
      e_fv = (pend.size() > 0) && pend[0].reg_we;
      e_we = e_fv && !bif.hold;
      e_cq = {m_nzcv, 28'h0};
      e_cf = ((pend.size() > 0) && pend[0].flag_we) ? {pend[0].flags, 28'h0} : e_cq;
      errs = 0;
      if (bif.in_ready !== !bif.hold || bif.rf_we !== e_we || bif.fwd_valid !== e_fv) errs++;
      if (e_fv && (bif.rf_waddr !== pend[0].dst || bif.rf_wdata !== pend[0].result ||
                   bif.fwd_dst !== pend[0].dst || bif.fwd_data !== pend[0].result)) errs++;
      if (bif.cpsr_q !== e_cq || bif.cpsr_fwd !== e_cf) errs++;
      if (bif.retired !== m_retired || bif4.retired !== m_retired[3:0]) errs++;
      n_checks++;
      if (errs != 0) begin
        n_fail++; $display("FAIL random_c%0d got rf_we=%b fwd_valid=%b cpsr_q=%h cpsr_fwd=%h retired=%0d/%0d exp %b %b %h %h %0d/%0d",
                           c, bif.rf_we, bif.fwd_valid, bif.cpsr_q, bif.cpsr_fwd, bif.retired, bif4.retired,
                           e_we, e_fv, e_cq, e_cf, m_retired, m_retired[3:0]);
      end
      tick();
    end
    bif.hold = 1'b0; bif.flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_wrap();
    #1;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      offer(1'b1, 32'(c), 32'h0, 3'(c), 1'b1, 1'b0);
      tick();
    end
    offer(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (bif4.retired !== 4'd15) begin
      n_fail++; $display("FAIL wrap_pre got retired4=%0d exp 15", bif4.retired);
    end
    tick();
    n_checks++;
    if (bif4.retired !== 4'd0 || bif.retired !== 32'd16) begin
      n_fail++; $display("FAIL wrap got retired4=%0d retired=%0d exp 0 16", bif4.retired, bif.retired);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_flags();
    test_hold();
    test_flush();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
